// File: rtl/seg_scan_if.sv
// Display-side bus of the segment scan driver: per-digit patterns and enable in,
// multiplexed segment/digit drive and frame tick out.
interface seg_scan_if;
    logic [7:0] SEG_PAT_1;
    logic [7:0] SEG_PAT_2;
    logic [7:0] SEG_PAT_3;
    logic [7:0] SEG_PAT_4;
    logic [7:0] SEG_PAT_5;
    logic [7:0] SEG_PAT_6;
    logic [7:0] SEG_PAT_7;
    logic [7:0] SEG_PAT_8;
    logic       EN;
    logic [7:0] SEG_OUT;
    logic [7:0] DIG_SEL;
    logic       FRAME_TICK;

    // Pattern source (e.g. display controller or testbench)
    modport master (
        output SEG_PAT_1, SEG_PAT_2, SEG_PAT_3, SEG_PAT_4,
        output SEG_PAT_5, SEG_PAT_6, SEG_PAT_7, SEG_PAT_8,
        output EN,
        input  SEG_OUT, DIG_SEL, FRAME_TICK
    );

    // Scan driver
    modport slave (
        input  SEG_PAT_1, SEG_PAT_2, SEG_PAT_3, SEG_PAT_4,
        input  SEG_PAT_5, SEG_PAT_6, SEG_PAT_7, SEG_PAT_8,
        input  EN,
        output SEG_OUT, DIG_SEL, FRAME_TICK
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed 7-segment scan driver.
// Each digit owns a slot of SCAN_DIV cycles; the first BLANK_CYC cycles of a slot
// are forced dark to stop ghosting while the digit select switches over.
// The digit pattern is latched once at slot start so mid-slot updates never tear.
// Legal parameters: BLANK_CYC >= 2 and SCAN_DIV >= BLANK_CYC + 2.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 2500,
    parameter int BLANK_CYC = 250
) (
    input  logic      CLK,
    input  logic      RSTN,
    seg_scan_if.slave bus
);
    // Counter is exactly wide enough for SCAN_DIV-1
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    pat_l_q, pat_l_d;
    logic [7:0]    seg_q, seg_d;
    logic [7:0]    dig_q, dig_d;
    logic          tick_q, tick_d;
    logic [7:0]    pat_sel;
    logic          cnt_wrap;
    logic          show;

    // Select the pattern of the digit currently being scanned
    always_comb begin
        pat_sel = 8'h00;
        case (idx_q)
            3'd0:    pat_sel = bus.SEG_PAT_1;
            3'd1:    pat_sel = bus.SEG_PAT_2;
            3'd2:    pat_sel = bus.SEG_PAT_3;
            3'd3:    pat_sel = bus.SEG_PAT_4;
            3'd4:    pat_sel = bus.SEG_PAT_5;
            3'd5:    pat_sel = bus.SEG_PAT_6;
            3'd6:    pat_sel = bus.SEG_PAT_7;
            default: pat_sel = bus.SEG_PAT_8;
        endcase
    end

    // Next-state: slot timing runs regardless of EN so frame rate never depends on it
    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = cnt_wrap ? idx_q + 3'd1 : idx_q;
        pat_l_d  = (cnt_q == '0) ? pat_sel : pat_l_q;
        // CNT==0 is always inside the blank window, so the latch update is never visible
        show     = (cnt_q >= CNT_BLANK) && bus.EN;
        dig_d    = show ? (8'h01 << idx_q) : 8'h00;
        seg_d    = show ? pat_l_q : 8'h00;
        tick_d   = cnt_wrap && (idx_q == 3'd7);
    end

    // State and registered outputs; reset darkens the display immediately
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            pat_l_q <= 8'h00;
            seg_q   <= 8'h00;
            dig_q   <= 8'h00;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pat_l_q <= pat_l_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.SEG_OUT    = seg_q;
    assign bus.DIG_SEL    = dig_q;
    assign bus.FRAME_TICK = tick_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver against a time-based model:
// after k clock edges since reset release, slot = k / SCAN_DIV, digit = slot % 8.
module tb_seg_scan_driver;
    localparam int D = 10;
    localparam int B = 2;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [7:0] pat [8];
    logic       en;

    int         n_vec = 0;
    int         n_err = 0;
    int         k     = 0;
    int         ticks = 0;
    logic [7:0] lat;
    logic [7:0] e_dig, e_seg;
    logic       e_tick;

    seg_scan_if sif();

    assign sif.SEG_PAT_1 = pat[0];
    assign sif.SEG_PAT_2 = pat[1];
    assign sif.SEG_PAT_3 = pat[2];
    assign sif.SEG_PAT_4 = pat[3];
    assign sif.SEG_PAT_5 = pat[4];
    assign sif.SEG_PAT_6 = pat[5];
    assign sif.SEG_PAT_7 = pat[6];
    assign sif.SEG_PAT_8 = pat[7];
    assign sif.EN        = en;

    seg_scan_driver #(.SCAN_DIV(D), .BLANK_CYC(B)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (sif)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // One clock edge: model the edge, then check DUT outputs on the falling edge
    task automatic step();
        int cnt, idx;
        @(posedge CLK);
        cnt = k % D;
        idx = (k / D) % 8;
        if (cnt == 0) lat = pat[idx];
        e_tick = (cnt == D - 1) && (idx == 7);
        if (cnt >= B && en) begin
            e_dig = 8'(1 << idx);
            e_seg = lat;
        end else begin
            e_dig = 8'h00;
            e_seg = 8'h00;
        end
        k++;
        @(negedge CLK);
        chk("dig_sel", sif.DIG_SEL, e_dig);
        chk("seg_out", sif.SEG_OUT, e_seg);
        chk("frame_tick", {7'b0, sif.FRAME_TICK}, {7'b0, e_tick});
        chk("onehot0", {7'b0, $onehot0(sif.DIG_SEL)}, 8'h01);
        if (sif.DIG_SEL == 8'h00) chk("dark_seg", sif.SEG_OUT, 8'h00);
        if (sif.FRAME_TICK) ticks++;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_dig"}, sif.DIG_SEL, 8'h00);
        chk({tag, "_seg"}, sif.SEG_OUT, 8'h00);
        chk({tag, "_tick"}, {7'b0, sif.FRAME_TICK}, 8'h00);
    endtask

    initial begin
        RSTN = 1'b0;
        en   = 1'b1;
        lat  = 8'h00;
        for (int i = 0; i < 8; i++) pat[i] = 8'((i + 1) * 16);
        #23;
        chk_dark("reset");

        // Reset release: 3 dark cycles, digit 1 for 8, 2 dark, then digit 2
        @(negedge CLK);
        RSTN = 1'b1;
        k    = 0;
        lat  = 8'h00;
        chk_dark("release");
        repeat (3) step();
        chk("first_dig", sif.DIG_SEL, 8'h01);
        chk("first_seg", sif.SEG_OUT, 8'h10);
        repeat (10) step();
        chk("second_dig", sif.DIG_SEL, 8'h02);
        chk("second_seg", sif.SEG_OUT, 8'h20);

        // Full frame: exactly one tick per 80 cycles
        ticks = 0;
        repeat (80) step();
        chk("ticks_per_frame", 8'(ticks), 8'h01);

        // Mid-show pattern change only shows up next frame
        pat[0] = 8'hFC;
        while (k % 80 != 5) step();
        pat[0] = 8'h60;
        step();
        chk("latched_old", sif.SEG_OUT, 8'hFC);
        while (k % 80 != 5) step();
        step();
        chk("latched_new", sif.SEG_OUT, 8'h60);

        // Display disabled for 15 cycles mid-show; timing keeps running
        en = 1'b0;
        repeat (15) step();
        en = 1'b1;
        while (k % D != B) step();
        step();
        chk("resume_dig", sif.DIG_SEL, 8'h04);

        // Reset at CNT=5 of digit 4
        while (k % 80 != 35) step();
        chk("pre_rst_dig", sif.DIG_SEL, 8'h08);
        #2 RSTN = 1'b0;
        #1 chk_dark("midslot_rst");
        @(negedge CLK);
        chk_dark("rst_hold");
        @(negedge CLK);
        RSTN = 1'b1;
        k    = 0;
        lat  = 8'h00;
        repeat (3) step();
        chk("restart_dig", sif.DIG_SEL, 8'h01);
        chk("restart_seg", sif.SEG_OUT, 8'h60);

        // Random patterns and enable
        repeat (10000) begin
            if ($urandom_range(7) == 0) en = ~en;
            if ($urandom_range(3) == 0) pat[$urandom_range(7)] = 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 2500, meaning CLK cycles per digit slot.
REQ-002 SHALL have parameter BLANK_CYC, default 250, meaning blanked cycles at the start of each slot (anti-ghosting).
REQ-003 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports SEG_PAT_1..SEG_PAT_8  input  8 each  segment patterns per digit, bit7=a .. bit1=g, bit0=dp, 1=lit.
REQ-006 SHALL have port EN  input  1  display enable; 0 = blank all digits.
REQ-007 SHALL have port SEG_OUT  output  8  shared segment bus, same bit order, 1=lit.
REQ-008 SHALL have port DIG_SEL  output  8  one-hot digit select, bit0=digit 1, 1=digit on.
REQ-009 SHALL have port FRAME_TICK  output  1  one-cycle pulse at end of each 8-digit frame.

Function
REQ-010 SHALL hold a slot counter CNT, range 0..SCAN_DIV-1, incrementing every CLK and wrapping to 0 after SCAN_DIV-1.
REQ-011 SHALL hold a digit index IDX, range 0..7, advancing by 1 only on a CNT wrap, with 7 wrapping to 0.
REQ-012 SHALL load latch PAT_L with SEG_PAT_(IDX+1) in each cycle where CNT==0, so pattern changes mid-slot never reach SEG_OUT.
REQ-013 SHALL treat each slot as two phases: BLANK while CNT<BLANK_CYC, SHOW while CNT>=BLANK_CYC.
REQ-014 SHALL register all outputs, so the outputs in cycle t+1 are a function of CNT, IDX, EN and PAT_L in cycle t.
REQ-015 SHALL, during SHOW with EN=1, drive DIG_SEL=(1<<IDX) and SEG_OUT=PAT_L.
REQ-016 SHALL, during BLANK or whenever EN=0, drive DIG_SEL=8'h00 and SEG_OUT=8'h00.
REQ-017 SHALL keep CNT and IDX running while EN=0, so frame timing is independent of EN.
REQ-018 SHALL pulse FRAME_TICK high for exactly one cycle, in the cycle after CNT==SCAN_DIV-1 with IDX==7.
REQ-019 SHALL never assert more than one DIG_SEL bit in any cycle, including across slot boundaries and EN toggles.
REQ-020 SHALL show consecutive digits with at least BLANK_CYC all-off cycles between them.
REQ-021 SHALL require BLANK_CYC>=2 and SCAN_DIV>=BLANK_CYC+2.
REQ-022 SHALL size CNT width to hold SCAN_DIV-1 exactly; no overflow beyond SCAN_DIV-1 is allowed.
REQ-023 SHALL, when EN rises mid-SHOW, light the current digit from the next cycle, with the current PAT_L and no restart of the slot.

Reset
REQ-024 SHALL, while RSTN=0, force CNT=0, IDX=0, PAT_L=8'h00, SEG_OUT=8'h00, DIG_SEL=8'h00 and FRAME_TICK=0, immediately and independent of CLK.
REQ-025 SHALL, after RSTN deasserts, start with a BLANK phase of digit 1, with PAT_L loaded on the first CLK edge.
REQ-026 SHALL, on reset mid-slot, abandon the slot without completing it, with outputs dark from reset assertion.

Verification (SCAN_DIV=10, BLANK_CYC=2)
REQ-027 SHALL verify reset release with SEG_PAT_n=8'h10*n and EN=1 -> DIG_SEL=00 for 3 cycles, then 8'h01 with SEG_OUT=8'h10 for 8 cycles, then 00 for 2 cycles, then 8'h02 with SEG_OUT=8'h20.
REQ-028 SHALL verify a full frame -> DIG_SEL walks 01,02,04,..,80, then 01; FRAME_TICK pulses once per 80 cycles, in the cycle after the digit-8 slot ends.
REQ-029 SHALL verify that changing SEG_PAT_1 from 8'hFC to 8'h60 during the digit-1 SHOW phase -> SEG_OUT stays 8'hFC to the slot end, and shows 8'h60 on the next frame.
REQ-030 SHALL verify EN=0 for 15 cycles mid-SHOW -> outputs 00 from the next cycle, IDX still advances, and the display resumes on the correct digit.
REQ-031 SHALL verify RSTN asserted at CNT=5 of digit 4 -> outputs 00 immediately, and restart at digit 1 after release.
REQ-032 SHALL verify, with random SEG_PAT and EN over 10k cycles, that DIG_SEL is one-hot or zero, and SEG_OUT=00 whenever DIG_SEL=00.
